// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester round-robin arbiter in front of a 16-bank memory.
// Requester 0 is the vector unit and requester 1 is the scalar unit.
// One transaction is in flight at a time: IDLE -> ISSUE -> (WAIT) -> RESP.
// Defining MEM_ARB_PERF_EN adds 16-bit saturating per-requester grant counters
// (perf_grants0 / perf_grants1).
//
// Handshake: req_ready[i] is a single-cycle accept pulse, raised only in IDLE
// and only for the requester that wins arbitration while its req_valid is high.
// The request is latched on the clock edge that ends that cycle. rsp_valid[i]
// is a single-cycle completion pulse; rsp_q is meaningful only while it is high.
module mem_arbiter (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [1:0][17:0]       req_addr,
  input  logic [1:0]             req_wren,
  input  logic [1:0]             req_vec,
  input  logic [1:0][15:0][31:0] req_data,
  output logic [17:0]            mem_address,
  output logic [15:0][31:0]      mem_data,
  output logic                   mem_wren,
  output logic                   mem_vec_scalar,
  input  logic [15:0][31:0]      mem_q,
  output logic [1:0]             rsp_valid,
  output logic [15:0][31:0]      rsp_q,
  output logic                   busy,
  output logic [1:0]             state
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [15:0]            perf_grants0,
  output logic [15:0]            perf_grants1
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]        state_q;
  logic [1:0]        state_d;
  logic              last_grant;
  logic              grant_sel;
  logic              accept;
  logic              lat_owner;
  logic              lat_wren;
  logic [15:0][31:0] data_fmt;

  // Arbitration: contention goes to the requester not granted last time.
  always_comb begin
    accept    = 1'b0;
    grant_sel = 1'b0;
    req_ready = 2'b00;
    if (req_valid == 2'b11) begin
      grant_sel = ~last_grant;
    end else begin
      grant_sel = req_valid[1];
    end
    if (!rst && (state_q == S_IDLE) && (req_valid != 2'b00)) begin
      accept    = 1'b1;
      req_ready = grant_sel ? 2'b10 : 2'b01;
    end
  end

  // Write data as the memory sees it: scalar low half-word goes to lane 15.
  always_comb begin
    data_fmt = '0;
    if (req_vec[grant_sel]) begin
      data_fmt = req_data[grant_sel];
    end else begin
      data_fmt[15] = {16'h0000, req_data[grant_sel][0][15:0]};
    end
  end

  // Next-state logic; writes skip WAIT because no read data is needed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_ISSUE;
      S_ISSUE: state_d = lat_wren ? S_RESP : S_WAIT;
      S_WAIT:  state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register and request latch; the latch is only loaded on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      last_grant     <= 1'b1;
      lat_owner      <= 1'b0;
      lat_wren       <= 1'b0;
      mem_vec_scalar <= 1'b0;
      mem_address    <= '0;
      mem_data       <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        last_grant     <= grant_sel;
        lat_owner      <= grant_sel;
        lat_wren       <= req_wren[grant_sel];
        mem_vec_scalar <= req_vec[grant_sel];
        mem_address    <= req_addr[grant_sel];
        mem_data       <= data_fmt;
      end
    end
  end

  // Strobes and response; all are held low while rst is asserted so a
  // reset in the middle of a transaction never leaks a write or a response.
  always_comb begin
    mem_wren  = !rst && (state_q == S_ISSUE) && lat_wren;
    busy      = !rst && (state_q != S_IDLE);
    state     = state_q;
    rsp_valid = 2'b00;
    rsp_q     = '0;
    if (!rst && (state_q == S_RESP)) begin
      rsp_valid = lat_owner ? 2'b10 : 2'b01;
      if (!lat_wren) begin
        if (mem_vec_scalar) begin
          rsp_q = mem_q;
        end else begin
          rsp_q[0] = mem_q[0];
        end
      end
    end
  end

`ifdef MEM_ARB_PERF_EN
  // Per-requester accept counters, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_grants0 <= '0;
      perf_grants1 <= '0;
    end else if (accept) begin
      if (!grant_sel && (perf_grants0 != 16'hFFFF)) perf_grants0 <= perf_grants0 + 16'd1;
      if (grant_sel && (perf_grants1 != 16'hFFFF)) perf_grants1 <= perf_grants1 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter. Inputs change 1 ns after the rising
// edge, outputs are sampled on the falling edge. The memory model returns
// a registered, address-dependent pattern so read data tracks mem_address.
module tb_mem_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst;
  logic [1:0]             req_valid;
  logic [1:0]             req_ready;
  logic [1:0][17:0]       req_addr;
  logic [1:0]             req_wren;
  logic [1:0]             req_vec;
  logic [1:0][15:0][31:0] req_data;
  logic [17:0]            mem_address;
  logic [15:0][31:0]      mem_data;
  logic                   mem_wren;
  logic                   mem_vec_scalar;
  logic [15:0][31:0]      mem_q;
  logic [1:0]             rsp_valid;
  logic [15:0][31:0]      rsp_q;
  logic                   busy;
  logic [1:0]             state;
`ifdef MEM_ARB_PERF_EN
  logic [15:0]            perf_grants0;
  logic [15:0]            perf_grants1;
`endif

  int checks = 0;
  int failures = 0;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wren(req_wren), .req_vec(req_vec),
    .req_data(req_data),
    .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren),
    .mem_vec_scalar(mem_vec_scalar), .mem_q(mem_q),
    .rsp_valid(rsp_valid), .rsp_q(rsp_q), .busy(busy), .state(state)
`ifdef MEM_ARB_PERF_EN
    , .perf_grants0(perf_grants0), .perf_grants1(perf_grants1)
`endif
  );

  // ---------------- memory model ----------------
  function automatic logic [15:0][31:0] mem_model(input logic [17:0] a);
    logic [15:0][31:0] r;
    logic [17:0] ak;
    for (int k = 0; k < 16; k++) begin
      ak = a + 18'(k);
      r[k] = 32'hC0DE0000 ^ {14'h0000, ak};
    end
    return r;
  endfunction

  always @(posedge clk) mem_q <= mem_model(mem_address);

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    req_valid = 2'b00;
    tick();
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    tick();
    rst = 1'b1;
    req_valid = 2'b11;
    tick();
    @(negedge clk);
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL rst_state: got %0d want 0", state); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL rst_ready: got %b want 00", req_ready); end
    checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL rst_rsp_valid: got %b want 00", rsp_valid); end
    checks++; if (mem_wren !== 1'b0) begin failures++; $display("FAIL rst_wren: got %b want 0", mem_wren); end
    checks++; if (mem_address !== 18'h0) begin failures++; $display("FAIL rst_addr: got %h want 0", mem_address); end
    checks++; if (mem_data !== '0) begin failures++; $display("FAIL rst_data: got %h want 0", mem_data); end
    checks++; if (rsp_q !== '0) begin failures++; $display("FAIL rst_rsp_q: got %h want 0", rsp_q); end
    checks++; if (mem_vec_scalar !== 1'b0) begin failures++; $display("FAIL rst_vs: got %b want 0", mem_vec_scalar); end
`ifdef MEM_ARB_PERF_EN
    checks++; if (perf_grants0 !== 16'h0 || perf_grants1 !== 16'h0) begin
      failures++; $display("FAIL rst_perf: got %h/%h want 0/0", perf_grants0, perf_grants1); end
`endif
    tick();
    rst = 1'b0;
    req_valid = 2'b00;
  endtask

  task automatic test_vector_read();
    logic [15:0][31:0] exp;
    exp = mem_model(18'h00100);
    tick();
    req_valid = 2'b01;
    req_addr[0] = 18'h00100; req_wren[0] = 1'b0; req_vec[0] = 1'b1;
    for (int k = 0; k < 16; k++) req_data[0][k] = 32'h10000000 + 32'(k);
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL vr_ready: got %b want 01", req_ready); end
    tick();
    req_valid = 2'b00;
    req_addr[0] = 18'h3FFFF;
    req_wren[0] = 1'b1;
    @(negedge clk);
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL vr_issue_state: got %0d want 1", state); end
    checks++; if (mem_address !== 18'h00100) begin failures++; $display("FAIL vr_addr: got %h want 00100", mem_address); end
    checks++; if (mem_wren !== 1'b0) begin failures++; $display("FAIL vr_wren_issue: got %b want 0", mem_wren); end
    checks++; if (mem_vec_scalar !== 1'b1) begin failures++; $display("FAIL vr_vs: got %b want 1", mem_vec_scalar); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL vr_busy: got %b want 1", busy); end
    tick();
    @(negedge clk);
    checks++; if (state !== 2'd2) begin failures++; $display("FAIL vr_wait_state: got %0d want 2", state); end
    checks++; if (rsp_valid !== 2'b00 || mem_wren !== 1'b0) begin
      failures++; $display("FAIL vr_wait_out: got rsp %b wren %b want 00 0", rsp_valid, mem_wren); end
    tick();
    @(negedge clk);
    checks++; if (rsp_valid !== 2'b01) begin failures++; $display("FAIL vr_rsp_valid: got %b want 01", rsp_valid); end
    checks++; if (rsp_q !== exp) begin failures++; $display("FAIL vr_rsp_q: got %h want %h", rsp_q, exp); end
    tick();
    @(negedge clk);
    checks++; if (state !== 2'd0 || rsp_valid !== 2'b00) begin
      failures++; $display("FAIL vr_idle: got state %0d rsp %b want 0 00", state, rsp_valid); end
  endtask

  task automatic test_scalar_write();
    logic [15:0][31:0] exp;
    exp = '0;
    exp[15] = 32'h0000BEEF;
    tick();
    req_valid = 2'b10;
    req_addr[1] = 18'h00020; req_wren[1] = 1'b1; req_vec[1] = 1'b0;
    req_data[1] = '0;
    req_data[1][0] = 32'h1234BEEF;
    req_data[1][15] = 32'hFFFFFFFF;
    @(negedge clk);
    checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL sw_ready: got %b want 10", req_ready); end
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    checks++; if (mem_wren !== 1'b1) begin failures++; $display("FAIL sw_wren: got %b want 1", mem_wren); end
    checks++; if (mem_address !== 18'h00020) begin failures++; $display("FAIL sw_addr: got %h want 00020", mem_address); end
    checks++; if (mem_data !== exp) begin failures++; $display("FAIL sw_data: got %h want %h", mem_data, exp); end
    checks++; if (mem_vec_scalar !== 1'b0) begin failures++; $display("FAIL sw_vs: got %b want 0", mem_vec_scalar); end
    tick();
    @(negedge clk);
    checks++; if (mem_wren !== 1'b0) begin failures++; $display("FAIL sw_wren_off: got %b want 0", mem_wren); end
    checks++; if (rsp_valid !== 2'b10) begin failures++; $display("FAIL sw_rsp_valid: got %b want 10", rsp_valid); end
    checks++; if (rsp_q !== '0) begin failures++; $display("FAIL sw_rsp_q: got %h want 0", rsp_q); end
    tick();
    @(negedge clk);
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL sw_idle: got %0d want 0", state); end
  endtask

  task automatic test_scalar_read_wrap();
    logic [15:0][31:0] full;
    logic [15:0][31:0] exp;
    full = mem_model(18'h3FFFF);
    exp = '0;
    exp[0] = full[0];
    tick();
    req_valid = 2'b01;
    req_addr[0] = 18'h3FFFF; req_wren[0] = 1'b0; req_vec[0] = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL sr_ready: got %b want 01", req_ready); end
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    checks++; if (mem_address !== 18'h3FFFF) begin failures++; $display("FAIL sr_addr: got %h want 3ffff", mem_address); end
    tick();
    tick();
    @(negedge clk);
    checks++; if (rsp_valid !== 2'b01) begin failures++; $display("FAIL sr_rsp_valid: got %b want 01", rsp_valid); end
    checks++; if (rsp_q !== exp) begin failures++; $display("FAIL sr_rsp_q: got %h want %h", rsp_q, exp); end
  endtask

  task automatic test_round_robin();
    int acc, cyc, last_cyc, r0, r1;
    logic last_own;
    logic [1:0] exp_rdy;
    do_reset();
    req_valid = 2'b11;
    req_addr[0] = 18'h00010; req_wren[0] = 1'b1; req_vec[0] = 1'b0;
    req_addr[1] = 18'h00200; req_wren[1] = 1'b0; req_vec[1] = 1'b1;
    acc = 0; cyc = 0; last_cyc = 0; r0 = 0; r1 = 0; last_own = 1'b0;
    while (acc < 6 && cyc < 60) begin
      @(negedge clk);
      checks++; if (req_ready === 2'b11) begin failures++; $display("FAIL rr_both: got %b want not 11", req_ready); end
      if (rsp_valid[0]) r0++;
      if (rsp_valid[1]) r1++;
      if (req_ready !== 2'b00) begin
        exp_rdy = (acc % 2 == 0) ? 2'b01 : 2'b10;
        checks++; if (req_ready !== exp_rdy) begin
          failures++; $display("FAIL rr_grant%0d: got %b want %b", acc, req_ready, exp_rdy); end
        if (acc > 0) begin
          checks++; if (cyc - last_cyc != (last_own ? 4 : 3)) begin
            failures++; $display("FAIL rr_gap%0d: got %0d want %0d", acc, cyc - last_cyc, last_own ? 4 : 3); end
        end
        last_cyc = cyc;
        last_own = req_ready[1];
        acc++;
      end
      tick();
      cyc++;
    end
    req_valid = 2'b00;
    checks++; if (acc != 6) begin failures++; $display("FAIL rr_timeout: got %0d accepts want 6", acc); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid[0]) r0++;
      if (rsp_valid[1]) r1++;
      tick();
    end
    checks++; if (r0 != 3 || r1 != 3) begin failures++; $display("FAIL rr_rsp_count: got %0d/%0d want 3/3", r0, r1); end
  endtask

  task automatic test_reset_mid();
    int seen;
    // read by requester 1, reset during WAIT
    tick();
    req_valid = 2'b10;
    req_addr[1] = 18'h00040; req_wren[1] = 1'b0; req_vec[1] = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL rm_ready: got %b want 10", req_ready); end
    tick();
    req_valid = 2'b00;
    tick();
    rst = 1'b1;
    @(negedge clk);
    checks++; if (state !== 2'd2) begin failures++; $display("FAIL rm_wait_state: got %0d want 2", state); end
    checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL rm_rsp_in_rst: got %b want 00", rsp_valid); end
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (state !== 2'd0 || busy !== 1'b0) begin
      failures++; $display("FAIL rm_after: got state %0d busy %b want 0 0", state, busy); end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid !== 2'b00) seen++;
      tick();
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL rm_no_rsp: got %0d pulses want 0", seen); end
    // write by requester 0, reset during ISSUE
    req_valid = 2'b01;
    req_addr[0] = 18'h00333; req_wren[0] = 1'b1; req_vec[0] = 1'b0;
    tick();
    req_valid = 2'b00;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL rm_issue_state: got %0d want 1", state); end
    checks++; if (mem_wren !== 1'b0) begin failures++; $display("FAIL rm_wren_in_rst: got %b want 0", mem_wren); end
    tick();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (mem_wren !== 1'b0 || rsp_valid !== 2'b00) seen++;
      tick();
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL rm_write_dropped: got %0d events want 0", seen); end
    checks++; if (mem_address !== 18'h0) begin failures++; $display("FAIL rm_addr_cleared: got %h want 0", mem_address); end
  endtask

  task automatic test_ignored_valid();
    logic [15:0][31:0] exp;
    tick();
    req_valid = 2'b01;
    req_addr[0] = 18'h00080; req_wren[0] = 1'b1; req_vec[0] = 1'b1;
    for (int k = 0; k < 16; k++) req_data[0][k] = 32'hA0000000 + 32'($urandom_range(0, 65535));
    exp = req_data[0];
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL iv_ready: got %b want 01", req_ready); end
    tick();
    req_valid = 2'b10;
    req_addr[1] = 18'h01111; req_wren[1] = 1'b1; req_vec[1] = 1'b0;
    req_data[0] = '0;
    req_addr[0] = 18'h00000;
    @(negedge clk);
    checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL iv_ready_busy: got %b want 00", req_ready); end
    checks++; if (mem_data !== exp) begin failures++; $display("FAIL iv_data: got %h want %h", mem_data, exp); end
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    checks++; if (rsp_valid !== 2'b01) begin failures++; $display("FAIL iv_rsp: got %b want 01", rsp_valid); end
    tick();
    @(negedge clk);
    checks++; if (req_ready !== 2'b00 || state !== 2'd0) begin
      failures++; $display("FAIL iv_ignored: got ready %b state %0d want 00 0", req_ready, state); end
    checks++; if (mem_address !== 18'h00080 || mem_data !== exp) begin
      failures++; $display("FAIL iv_hold: got addr %h want 00080", mem_address); end
  endtask

  task automatic test_back_to_back();
    tick();
    req_valid = 2'b01;
    req_addr[0] = 18'h00005; req_wren[0] = 1'b1; req_vec[0] = 1'b0;
    req_data[0] = '0;
    req_data[0][0] = 32'h00001111;
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL bb_ready0: got %b want 01", req_ready); end
    tick();
    req_data[0][0] = 32'h00002222;
    @(negedge clk);
    checks++; if (mem_data[15] !== 32'h00001111 || req_ready !== 2'b00) begin
      failures++; $display("FAIL bb_issue0: got lane15 %h ready %b want 00001111 00", mem_data[15], req_ready); end
    tick();
    @(negedge clk);
    checks++; if (rsp_valid !== 2'b01 || req_ready !== 2'b00) begin
      failures++; $display("FAIL bb_resp0: got rsp %b ready %b want 01 00", rsp_valid, req_ready); end
    tick();
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL bb_ready1: got %b want 01", req_ready); end
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    checks++; if (mem_data[15] !== 32'h00002222 || mem_wren !== 1'b1) begin
      failures++; $display("FAIL bb_issue1: got lane15 %h wren %b want 00002222 1", mem_data[15], mem_wren); end
    tick();
    tick();
  endtask

`ifdef MEM_ARB_PERF_EN
  task automatic test_perf();
    int acc, cyc;
    do_reset();
    req_valid = 2'b01;
    req_wren = 2'b11; req_vec = 2'b00;
    acc = 0; cyc = 0;
    while (acc < 5 && cyc < 40) begin
      @(negedge clk);
      if (req_ready[0]) acc++;
      tick();
      if (acc == 5) req_valid = 2'b00;
      cyc++;
    end
    req_valid = 2'b10;
    acc = 0; cyc = 0;
    while (acc < 2 && cyc < 40) begin
      @(negedge clk);
      if (req_ready[1]) acc++;
      tick();
      if (acc == 2) req_valid = 2'b00;
      cyc++;
    end
    tick(); tick(); tick();
    @(negedge clk);
    checks++; if (perf_grants0 !== 16'd5 || perf_grants1 !== 16'd2) begin
      failures++; $display("FAIL perf_counts: got %0d/%0d want 5/2", perf_grants0, perf_grants1); end
  endtask
`endif

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    req_valid = 2'b00;
    req_addr = '0;
    req_wren = 2'b00;
    req_vec = 2'b00;
    req_data = '0;
    test_reset();
    test_vector_read();
    test_scalar_write();
    test_scalar_read_wrap();
    test_round_robin();
    test_reset_mid();
    test_ignored_valid();
    test_back_to_back();
`ifdef MEM_ARB_PERF_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
